// File: rtl/pc_sequencer_if.sv
// Sequencer bus: control-unit request fields and PC/stack status returned.
// master = control side (drives op fields); slave = pc_sequencer.
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8,
  parameter int DEPTH = 4
);
  logic                         en;
  logic [2:0]                   seq_op;
  logic [PC_W-1:0]              target;
  logic [OFF_W-1:0]             offset;
  logic                         z;
  logic                         err_clr;
  logic [PC_W-1:0]              pc;
  logic [$clog2(DEPTH+1)-1:0]   sp;
  logic                         stack_empty;
  logic                         stack_full;
  logic [PC_W-1:0]              top;
  logic                         err_ovf;
  logic                         err_unf;

  modport master (
    output en, seq_op, target, offset, z, err_clr,
    input  pc, sp, stack_empty, stack_full, top, err_ovf, err_unf
  );

  modport slave (
    input  en, seq_op, target, offset, z, err_clr,
    output pc, sp, stack_empty, stack_full, top, err_ovf, err_unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with return stack; ports: clk, reset (async
// active-low), bus (slave). Macro PCSEQ_STACK_WRAP_EN makes the stack circular.
module pc_sequencer #(
  parameter int              PC_W      = 10,
  parameter int              OFF_W     = 8,
  parameter int              DEPTH     = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  localparam int SP_W = $clog2(DEPTH+1);
  localparam int PW   = $clog2(DEPTH);
  localparam logic [SP_W-1:0] FULL = SP_W'(DEPTH);
  localparam logic [PW-1:0]   LAST = PW'(DEPTH-1);

  logic [PC_W-1:0] pc_q, pc_d, pc_inc, pc_br;
  logic [PC_W-1:0] off_x;
  logic [PC_W-1:0] stk [DEPTH];
  logic [PC_W-1:0] top_v;
  logic [SP_W-1:0] sp_q;
  logic [PW-1:0]   wp_q, wp_up, wp_dn;
  logic            empty, full;
  logic            push, push_wr, pop;
  logic            ovf_ev, unf_ev;
  logic            ovf_q, unf_q;
  logic            op_jmp, op_br, op_jz;
  logic            op_jnz, op_call, op_ret;

  assign op_jmp  = bus.seq_op == 3'd1;
  assign op_br   = bus.seq_op == 3'd2;
  assign op_jz   = bus.seq_op == 3'd3;
  assign op_jnz  = bus.seq_op == 3'd4;
  assign op_call = bus.seq_op == 3'd5;
  assign op_ret  = bus.seq_op == 3'd6;

  assign off_x  = PC_W'($signed(bus.offset));
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_br  = pc_q + off_x;

  assign empty = sp_q == '0;
  assign full  = sp_q == FULL;

  // wp_q is the next free slot; newest entry sits just below it.
  assign wp_up = (wp_q == LAST) ? '0 : wp_q + PW'(1);
  assign wp_dn = (wp_q == '0) ? LAST : wp_q - PW'(1);
  assign top_v = stk[wp_dn];

  always_comb begin
    pc_d   = pc_q;
    push   = 1'b0;
    pop    = 1'b0;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    if (bus.en) begin
      unique case (1'b1)
        op_jmp: pc_d = bus.target;
        op_br:  pc_d = pc_br;
        op_jz:  pc_d = bus.z ? bus.target : pc_inc;
        op_jnz: pc_d = bus.z ? pc_inc : bus.target;
        op_call: begin
          pc_d   = bus.target;
          push   = 1'b1;
          ovf_ev = full;
        end
        op_ret: begin
          pop    = !empty;
          unf_ev = empty;
          pc_d   = empty ? pc_inc : top_v;
        end
        default: pc_d = pc_inc;
      endcase
    end
  end

`ifdef PCSEQ_STACK_WRAP_EN
  // Full stack: overwrite the oldest slot (the one wp_q points at).
  assign push_wr = push;
`else
  assign push_wr = push && !full;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      wp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (push_wr) begin
        stk[wp_q] <= pc_inc;
        wp_q      <= wp_up;
        if (!full) sp_q <= sp_q + SP_W'(1);
      end else if (pop) begin
        wp_q <= wp_dn;
        sp_q <= sp_q - SP_W'(1);
      end
      // An error event outranks a simultaneous clear.
      if (ovf_ev)           ovf_q <= 1'b1;
      else if (bus.err_clr) ovf_q <= 1'b0;
      if (unf_ev)           unf_q <= 1'b1;
      else if (bus.err_clr) unf_q <= 1'b0;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.sp          = sp_q;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
  assign bus.top         = empty ? '0 : top_v;
  assign bus.err_ovf     = ovf_q;
  assign bus.err_unf     = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus random ops
// checked against a queue-based return-stack model.
module tb_pc_sequencer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  pc_sequencer_if #(.PC_W(10), .OFF_W(8), .DEPTH(DEPTH)) bus ();

  pc_sequencer #(
    .PC_W(10), .OFF_W(8), .DEPTH(DEPTH), .RESET_VEC(10'h3FE)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [9:0] m_pc;
  logic [9:0] m_q[$];
  logic       m_ovf, m_unf;

  task automatic model_reset();
    m_pc = 10'h3FE;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  function automatic logic [9:0] m_top();
    return (m_q.size() == 0) ? 10'h000 : m_q[$];
  endfunction

  task automatic model_step(input logic [2:0] op, input logic [9:0] t,
                            input logic [7:0] o, input logic zz,
                            input logic e, input logic c);
    logic [9:0] nxt;
    nxt = 10'(int'(m_pc) + 1);
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (e) begin
      case (op)
        3'd1: m_pc = t;
        3'd2: m_pc = 10'(int'(m_pc) + int'($signed(o)));
        3'd3: m_pc = zz ? t : nxt;
        3'd4: m_pc = zz ? nxt : t;
        3'd5: begin
          if (m_q.size() == DEPTH) begin
            m_ovf = 1'b1;
`ifdef PCSEQ_STACK_WRAP_EN
            void'(m_q.pop_front());
            m_q.push_back(nxt);
`endif
          end else begin
            m_q.push_back(nxt);
          end
          m_pc = t;
        end
        3'd6: begin
          if (m_q.size() == 0) begin
            m_unf = 1'b1;
            m_pc  = nxt;
          end else begin
            m_pc = m_q.pop_back();
          end
        end
        default: m_pc = nxt;
      endcase
    end
  endtask

  task automatic step(input logic [2:0] op, input logic [9:0] t,
                      input logic [7:0] o, input logic zz,
                      input logic e, input logic c);
    bus.seq_op  = op;
    bus.target  = t;
    bus.offset  = o;
    bus.z       = zz;
    bus.en      = e;
    bus.err_clr = c;
    @(posedge clk);
    model_step(op, t, o, zz, e, c);
    #1;
  endtask

  task automatic op1(input logic [2:0] op, input logic [9:0] t);
    step(op, t, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    logic [9:0] exp [3];
    exp = '{10'h3FF, 10'h000, 10'h001};
    rst_n = 1'b0;
    model_reset();
    bus.en = 1'b0; bus.seq_op = 3'd0; bus.target = '0;
    bus.offset = '0; bus.z = 1'b0; bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.pc, bus.sp, bus.top} !== {10'h3FE, 3'd0, 10'h000}) begin
      n_fail++;
      $display("FAIL reset_pc_sp_top got %h/%0d/%h exp 3fe/0/000",
               bus.pc, bus.sp, bus.top);
    end
    n_chk++;
    if ({bus.stack_empty, bus.stack_full, bus.err_ovf, bus.err_unf} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags got %b%b%b%b exp 1000", bus.stack_empty,
               bus.stack_full, bus.err_ovf, bus.err_unf);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op1(3'd0, 10'h0);
      n_chk++;
      if (bus.pc !== exp[i]) begin
        n_fail++;
        $display("FAIL next_wrap[%0d] got %h exp %h", i, bus.pc, exp[i]);
      end
    end
  endtask

  task automatic test_branch();
    op1(3'd1, 10'h010);
    step(3'd2, 10'h0, 8'hF0, 1'b0, 1'b1, 1'b0);
    n_chk++;
    if (bus.pc !== 10'h000) begin
      n_fail++; $display("FAIL br_neg got %h exp 000", bus.pc);
    end
    step(3'd2, 10'h0, 8'h7F, 1'b0, 1'b1, 1'b0);
    n_chk++;
    if (bus.pc !== 10'h07F) begin
      n_fail++; $display("FAIL br_pos got %h exp 07f", bus.pc);
    end
    op1(3'd1, 10'h000);
    step(3'd2, 10'h0, 8'hFF, 1'b0, 1'b1, 1'b0);
    n_chk++;
    if (bus.pc !== 10'h3FF) begin
      n_fail++; $display("FAIL br_wrap got %h exp 3ff", bus.pc);
    end
  endtask

  task automatic test_cond();
    step(3'd3, 10'h100, 8'h0, 1'b1, 1'b1, 1'b0);
    n_chk++;
    if (bus.pc !== 10'h100) begin
      n_fail++; $display("FAIL jz_taken got %h exp 100", bus.pc);
    end
    step(3'd3, 10'h200, 8'h0, 1'b0, 1'b1, 1'b0);
    n_chk++;
    if (bus.pc !== 10'h101) begin
      n_fail++; $display("FAIL jz_not got %h exp 101", bus.pc);
    end
    step(3'd4, 10'h200, 8'h0, 1'b0, 1'b1, 1'b0);
    n_chk++;
    if (bus.pc !== 10'h200) begin
      n_fail++; $display("FAIL jnz_taken got %h exp 200", bus.pc);
    end
  endtask

  task automatic fill_stack();
    op1(3'd1, 10'h010);
    op1(3'd5, 10'h020);
    op1(3'd5, 10'h030);
    op1(3'd5, 10'h040);
    op1(3'd5, 10'h050);
  endtask

  task automatic test_stack();
    logic [9:0] exp [4];
    exp = '{10'h041, 10'h031, 10'h021, 10'h011};
    fill_stack();
    n_chk++;
    if ({bus.stack_full, bus.sp, bus.top} !== {1'b1, 3'd4, 10'h041}) begin
      n_fail++;
      $display("FAIL stack_full got full=%b sp=%0d top=%h exp 1/4/041",
               bus.stack_full, bus.sp, bus.top);
    end
    for (int i = 0; i < 4; i++) begin
      op1(3'd6, 10'h0);
      n_chk++;
      if (bus.pc !== exp[i]) begin
        n_fail++; $display("FAIL ret[%0d] got %h exp %h", i, bus.pc, exp[i]);
      end
    end
    n_chk++;
    if ({bus.stack_empty, bus.top} !== {1'b1, 10'h000}) begin
      n_fail++;
      $display("FAIL stack_empty got %b/%h exp 1/000", bus.stack_empty, bus.top);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] exp [4];
`ifdef PCSEQ_STACK_WRAP_EN
    exp = '{10'h051, 10'h041, 10'h031, 10'h021};
`else
    exp = '{10'h041, 10'h031, 10'h021, 10'h011};
`endif
    fill_stack();
    op1(3'd5, 10'h060);
    n_chk++;
    if ({bus.err_ovf, bus.pc, bus.sp} !== {1'b1, 10'h060, 3'd4}) begin
      n_fail++;
      $display("FAIL ovf got ovf=%b pc=%h sp=%0d exp 1/060/4",
               bus.err_ovf, bus.pc, bus.sp);
    end
    for (int i = 0; i < 4; i++) begin
      op1(3'd6, 10'h0);
      n_chk++;
      if (bus.pc !== exp[i]) begin
        n_fail++; $display("FAIL ovf_ret[%0d] got %h exp %h", i, bus.pc, exp[i]);
      end
    end
  endtask

  task automatic test_underflow();
    step(3'd0, 10'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if (bus.err_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clr got %b exp 0", bus.err_ovf);
    end
    op1(3'd1, 10'h005);
    op1(3'd6, 10'h0);
    n_chk++;
    if ({bus.pc, bus.err_unf, bus.sp} !== {10'h006, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL unf got pc=%h unf=%b sp=%0d exp 006/1/0",
               bus.pc, bus.err_unf, bus.sp);
    end
    step(3'd6, 10'h0, 8'h0, 1'b0, 1'b1, 1'b1);
    n_chk++;
    if ({bus.pc, bus.err_unf} !== {10'h007, 1'b1}) begin
      n_fail++;
      $display("FAIL unf_vs_clr got pc=%h unf=%b exp 007/1", bus.pc, bus.err_unf);
    end
    step(3'd5, 10'h123, 8'h0, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if ({bus.pc, bus.err_unf, bus.sp} !== {10'h007, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL clr_stalled got pc=%h unf=%b sp=%0d exp 007/0/0",
               bus.pc, bus.err_unf, bus.sp);
    end
  endtask

  task automatic test_random();
    logic [26:0] got, exp;
    logic [2:0]  op;
    int          r;
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 11);
      op = (r > 7) ? ((r < 10) ? 3'd5 : 3'd6) : 3'(r);
      step(op, 10'($urandom), 8'($urandom), 1'($urandom),
           $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
      got = {bus.pc, bus.sp, bus.top, bus.stack_empty,
             bus.stack_full, bus.err_ovf, bus.err_unf};
      exp = {m_pc, 3'(m_q.size()), m_top(), m_q.size() == 0,
             m_q.size() == DEPTH, m_ovf, m_unf};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d got %h exp %h", i, op, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    op1(3'd1, 10'h0AA);
    op1(3'd5, 10'h0BB);
    op1(3'd5, 10'h0CC);
    op1(3'd6, 10'h0);
    bus.seq_op = 3'd5;
    bus.target = 10'h155;
    bus.en     = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if ({bus.pc, bus.sp, bus.top, bus.stack_empty, bus.stack_full,
         bus.err_ovf, bus.err_unf} !== {10'h3FE, 3'd0, 10'h000, 4'b1000}) begin
      n_fail++;
      $display("FAIL reset_mid got pc=%h sp=%0d top=%h e=%b f=%b o=%b u=%b",
               bus.pc, bus.sp, bus.top, bus.stack_empty, bus.stack_full,
               bus.err_ovf, bus.err_unf);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    op1(3'd0, 10'h0);
    n_chk++;
    if ({bus.pc, bus.sp} !== {10'h3FF, 3'd0}) begin
      n_fail++;
      $display("FAIL after_reset got pc=%h sp=%0d exp 3ff/0", bus.pc, bus.sp);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_cond();
    test_stack();
    test_overflow();
    test_underflow();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the microcontroller datapath. It replaces the fixed 10-bit PC register, the incrementer/offset adders and the single-entry return register with one block. It has configurable PC width, signed relative branches, zero-flag conditional jumps, and a return-address stack of configurable depth with full/empty status and sticky error flags. It sits between the control unit (which supplies `seq_op`) and program memory (which consumes `pc`).

## Interface
Parameters:
- `PC_W`, 10, program counter and return-address width (≥4).
- `OFF_W`, 8, width of the signed relative offset (2..PC_W).
- `DEPTH`, 4, return-stack entries (≥2).
- `RESET_VEC`, 0, PC value after reset.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  advance enable; 0 = stall (all state held, `seq_op` ignored).
- `seq_op`  in  3  sequencing operation for the current instruction (see Operation).
- `target`  in  PC_W  absolute jump/call destination.
- `offset`  in  OFF_W  signed relative branch offset.
- `z`  in  1  registered zero flag from the ALU.
- `err_clr`  in  1  clears the sticky error flags.
- `pc`  out  PC_W  current program counter (registered).
- `sp`  out  $clog2(DEPTH+1)  number of valid stack entries.
- `stack_empty`  out  1  `sp == 0`.
- `stack_full`  out  1  `sp == DEPTH`.
- `top`  out  PC_W  top-of-stack value; 0 when empty.
- `err_ovf`  out  1  sticky: CALL issued while full.
- `err_unf`  out  1  sticky: RET issued while empty.

## Operation
`seq_op` encoding (evaluated only when `en=1`):
- 0 NEXT: pc ← pc+1.
- 1 JMP: pc ← target.
- 2 BR: pc ← pc + sign_ext(offset).
- 3 JZ: pc ← target if z, else pc+1.
- 4 JNZ: pc ← target if !z, else pc+1.
- 5 CALL: push pc+1; pc ← target.
- 6 RET: pc ← popped top.
- 7 reserved: behaves as NEXT.

Arithmetic and stack rules:
- All PC arithmetic is modulo 2^PC_W. Wrap-around is silent: pc = 2^PC_W−1 with NEXT gives 0. BR with offset −1 at pc 0 gives 2^PC_W−1.
- The stack is implemented as a register array plus pointer; no memory macro.
- The pushed value is pc+1 (wrapped).
- CALL when full: see Configuration. `err_ovf` is set in either build. The jump to `target` is always taken.
- RET when empty: pc ← pc+1, `sp` stays 0, `err_unf` is set.
- `err_clr` clears both flags on the next edge. If an error event coincides with `err_clr`, the event wins and the flag stays set. `err_clr` is honoured regardless of `en`.

## Timing
- Reset (asynchronous, `reset=0`): pc=RESET_VEC, sp=0, all stack entries 0, err_ovf=err_unf=0, stack_empty=1, stack_full=0, top=0. A reset during any operation aborts it immediately.
- Next-PC logic is combinational from current pc/inputs. pc, sp, stack entries and flags update on the same rising edge, giving one-cycle latency from `seq_op` to the new `pc`.
- `top`, `stack_empty` and `stack_full` are combinational from the registered stack state and valid in the cycle after a push or pop.
- Back-to-back CALL/RET on consecutive cycles is supported at full rate. Only one stack operation occurs per cycle, so there is no simultaneous push and pop.
- `en=0`: pc, sp, stack and error flags hold. `err_clr` still acts.

## Configuration
- `PCSEQ_STACK_WRAP_EN` defined: the stack is circular. CALL when full overwrites the oldest entry and `sp` stays DEPTH. Subsequent RETs return the newest DEPTH addresses in LIFO order.
- Not defined: CALL when full discards the push. Stack contents and `sp` are unchanged, and the later RET returns to the caller one level up.
- `err_ovf` behaviour is identical in both builds.

## Test plan
- Reset, then 3×NEXT, with PC_W=10 and RESET_VEC=0x3FE -> pc sequence 0x3FE, 0x3FF, 0x000, 0x001.
- At pc=0x010, BR offset=8'hF0 -> pc=0x000. Then BR offset=8'h7F -> pc=0x07F.
- z=1: JZ target=0x100 -> pc=0x100. Then z=0: JZ target=0x200 -> pc=0x101. Then JNZ target=0x200 -> pc=0x200.
- DEPTH=4: CALL from pc 0x10, 0x20, 0x30, 0x40 -> stack_full=1, top=0x41. Then 4×RET -> pc 0x41, 0x31, 0x21, 0x11, and stack_empty=1.
- From full, a fifth CALL from pc 0x50 -> err_ovf=1. With `PCSEQ_STACK_WRAP_EN`: 4×RET gives 0x51, 0x41, 0x31, 0x21. Without it: 4×RET gives 0x41, 0x31, 0x21, 0x11.
- RET when empty at pc=0x05 -> pc=0x06, err_unf=1. Then err_clr together with another RET on empty -> err_unf remains 1. Then err_clr alone -> err_unf=0. Assert reset mid-sequence -> all outputs at reset values immediately.
